// File: rtl/chan_512_if_switch_pkg.sv
// Shared definitions for the IF switch controller: FSM encoding and the
// bit layout of the software register word.
package chan_512_if_switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BLANK_PRE = 3'd1,
    ST_SWITCH    = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RELEASE   = 3'd4
  } state_e;

  localparam int SEL_LSB         = 0;
  localparam int FORCE_BLANK_BIT = 4;
  localparam int SETTLE_LSB      = 16;
  localparam int SETTLE_W        = 16;
  localparam int TIMER_W         = 16;

endpackage

// File: rtl/if_switch_timer.sv
// Loadable down-counter with a zero flag; times both the pre-switch
// blanking and the post-switch settle waits.
module if_switch_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/chan_512_if_switch_ctrl.sv
// IF switch sequencer: blanks the datapath, applies a new select, waits for
// the switch to settle, then releases with a one-cycle sync pulse.
module chan_512_if_switch_ctrl
  import chan_512_if_switch_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int PRE_CYC = 4,
  parameter int CNT_W   = 16
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic [31:0]      reg_in,
  output logic [SEL_W-1:0] sw_sel,
  output logic             blank,
  output logic             busy,
  output logic             sync_out,
  output logic [CNT_W-1:0] change_cnt,
  output state_e           dbg_state
);

  localparam logic [TIMER_W-1:0] PRE_LOAD = TIMER_W'(PRE_CYC - 1);

  logic [31:0]         reg_q;
  state_e              state_q, state_d;
  logic [SEL_W-1:0]    target_q, target_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SEL_W-1:0]    sw_sel_q, sw_sel_d;
  logic                blank_q, blank_d;
  logic                busy_q, busy_d;
  logic                sync_q, sync_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_dec;
  logic                tmr_zero;

  logic [SEL_W-1:0]    req_sel;
  logic [SETTLE_W-1:0] req_settle;
  logic                unused_reg_bits;

  assign req_sel         = reg_q[SEL_LSB +: SEL_W];
  assign req_settle      = reg_q[SETTLE_LSB +: SETTLE_W];
  assign unused_reg_bits = ^reg_q;

  if_switch_timer #(.W(TIMER_W)) u_timer (
    .clk_i      (user_clk),
    .rst_i      (user_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Timer is loaded with (count-1) on entry so each wait lasts exactly count cycles.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    settle_d = settle_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_sel != sw_sel_q) begin
          target_d = req_sel;
          settle_d = req_settle;
          tmr_load = 1'b1;
          tmr_val  = PRE_LOAD;
          state_d  = ST_BLANK_PRE;
        end
      end
      ST_BLANK_PRE: begin
        if (tmr_zero) state_d = ST_SWITCH;
        else          tmr_dec = 1'b1;
      end
      ST_SWITCH: begin
        if (settle_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(settle_q - SETTLE_W'(1));
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) state_d = ST_RELEASE;
        else          tmr_dec = 1'b1;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they line up with it once registered.
  // Force-blank uses the incoming word so blank tracks reg_q[4] cycle for cycle.
  always_comb begin
    sw_sel_d = (state_d == ST_SWITCH) ? target_q : sw_sel_q;
    blank_d  = (state_d == ST_BLANK_PRE) || (state_d == ST_SWITCH) ||
               (state_d == ST_SETTLE) || reg_in[FORCE_BLANK_BIT];
    busy_d   = (state_d != ST_IDLE);
    sync_d   = (state_d == ST_RELEASE);
    cnt_d    = (state_d == ST_RELEASE) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      reg_q    <= '0;
      state_q  <= ST_IDLE;
      target_q <= '0;
      settle_q <= '0;
      sw_sel_q <= '0;
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      reg_q    <= reg_in;
      state_q  <= state_d;
      target_q <= target_d;
      settle_q <= settle_d;
      sw_sel_q <= sw_sel_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sw_sel     = sw_sel_q;
  assign blank      = blank_q;
  assign busy       = busy_q;
  assign sync_out   = sync_q;
  assign change_cnt = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_chan_512_if_switch_ctrl.sv
// Scoreboard bench for the IF switch controller: each requested sequence
// pushes its expected select, count and blank length; a monitor checks them on sync_out.
module tb_chan_512_if_switch_ctrl;
  import chan_512_if_switch_pkg::*;

  localparam int SEL_W = 2;
  localparam int CNT_W = 16;
  localparam int EW    = SEL_W + CNT_W + 16;

  logic             user_clk = 1'b0;
  logic             user_rst = 1'b1;
  logic [31:0]      reg_in   = '0;
  logic [SEL_W-1:0] sw_sel;
  logic             blank;
  logic             busy;
  logic             sync_out;
  logic [CNT_W-1:0] change_cnt;
  state_e           dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               run_len = 0;

  chan_512_if_switch_ctrl #(.SEL_W(SEL_W), .PRE_CYC(4), .CNT_W(CNT_W)) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .reg_in     (reg_in),
    .sw_sel     (sw_sel),
    .blank      (blank),
    .busy       (busy),
    .sync_out   (sync_out),
    .change_cnt (change_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 user_clk = ~user_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [SEL_W-1:0] sel, input int blen);
    exp_cnt = exp_cnt + 1'b1;
    exp_q.push_back({sel, exp_cnt, 16'(blen)});
  endtask

  task automatic wait_state(input state_e s);
    int budget;
    budget = 0;
    while (dbg_state != s && budget < 200) begin
      @(negedge user_clk);
      budget++;
    end
    if (dbg_state != s) begin
      checks++;
      errors++;
      $display("FAIL wait_state: timeout waiting for state %0d, got %0d", s, dbg_state);
    end
  endtask

  task automatic wait_idle();
    int quiet;
    int budget;
    quiet  = 0;
    budget = 0;
    repeat (3) @(negedge user_clk);
    while (quiet < 3 && budget < 500) begin
      @(negedge user_clk);
      budget++;
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 3) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout, busy=%0b", busy);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge user_clk);
      if (user_rst) begin
        run_len = 0;
      end else begin
        if (sync_out) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sync: got sw_sel=%0d cnt=%0d, required no pulse", sw_sel, change_cnt);
          end else begin
            e = exp_q.pop_front();
            check("seq_sw_sel", 32'(sw_sel), 32'(e[EW-1 -: SEL_W]));
            check("seq_change_cnt", 32'(change_cnt), 32'(e[CNT_W+15:16]));
            check("seq_blank_len", 32'(run_len), 32'(e[15:0]));
            check("seq_busy_rel", 32'(busy), 32'd1);
            check("seq_blank_rel", 32'(blank), 32'd0);
          end
        end
        run_len = blank ? run_len + 1 : 0;
      end
    end
  end

  // driver
  initial begin
    repeat (3) @(negedge user_clk);
    check("rst_sw_sel", 32'(sw_sel), 0);
    check("rst_blank", 32'(blank), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sync", 32'(sync_out), 0);
    check("rst_cnt", 32'(change_cnt), 0);
    user_rst = 1'b0;
    @(negedge user_clk);

    // basic sequence with latency and switch-point checks
    reg_in = 32'h0003_0002;
    push_seq(2'd2, 8);
    @(negedge user_clk);
    check("lat_blank_n1", 32'(blank), 0);
    @(negedge user_clk);
    check("lat_blank_n2", 32'(blank), 1);
    check("lat_busy_n2", 32'(busy), 1);
    repeat (3) @(negedge user_clk);
    check("pre_switch_sel", 32'(sw_sel), 0);
    @(negedge user_clk);
    check("switch_sel", 32'(sw_sel), 2);
    wait_idle();

    // zero settle skips SETTLE
    reg_in = 32'h0000_0001;
    push_seq(2'd1, 5);
    wait_idle();

    // requests during SETTLE: only the latest is serviced afterwards
    reg_in = 32'h0005_0002;
    push_seq(2'd2, 10);
    wait_state(ST_SETTLE);
    reg_in = 32'h0005_0003;
    @(negedge user_clk);
    reg_in = 32'h0005_0001;
    push_seq(2'd1, 10);
    wait_idle();

    // revert during BLANK_PRE: completes, then returns
    reg_in = 32'h0000_0000;
    push_seq(2'd0, 5);
    wait_state(ST_BLANK_PRE);
    reg_in = 32'h0000_0001;
    push_seq(2'd1, 5);
    wait_idle();
    check("after_revert_sel", 32'(sw_sel), 1);

    // force blank with no select change
    reg_in = 32'h0000_0011;
    repeat (2) @(negedge user_clk);
    check("fb_blank", 32'(blank), 1);
    check("fb_busy", 32'(busy), 0);
    repeat (3) @(negedge user_clk);
    check("fb_blank_hold", 32'(blank), 1);
    check("fb_sync", 32'(sync_out), 0);
    check("fb_cnt", 32'(change_cnt), 32'(exp_cnt));
    reg_in = 32'h0000_0001;
    repeat (2) @(negedge user_clk);
    check("fb_clear", 32'(blank), 0);

    // asynchronous reset mid-SETTLE
    reg_in = 32'h0003_0002;
    wait_state(ST_SETTLE);
    #2 user_rst = 1'b1;
    #1;
    check("arst_sw_sel", 32'(sw_sel), 0);
    check("arst_blank", 32'(blank), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_sync", 32'(sync_out), 0);
    check("arst_cnt", 32'(change_cnt), 0);
    exp_cnt = '0;
    push_seq(2'd2, 8);
    repeat (2) @(negedge user_clk);
    user_rst = 1'b0;
    wait_idle();

    // counter wrap via backdoor preload
    force dut.cnt_q = 16'hFFFF;
    @(posedge user_clk);
    #1;
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    @(negedge user_clk);
    check("cnt_preload", 32'(change_cnt), 32'h0000_FFFF);
    reg_in = 32'h0000_0003;
    push_seq(2'd3, 5);
    wait_idle();
    check("cnt_wrapped", 32'(change_cnt), 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
